pipe_stage_buffer: RTL and testbench
====================================

# pipe_stage_buffer

Parametrised inter-stage pipeline register with a valid/ready handshake, a skid slot, synchronous flush and per-entry bubble insertion. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the fixed, always-capturing stage buffers. Width, register-address field count and the address "kill" code are parameters. The block adds back-pressure and flush behaviour, which the existing buffers lack.

## Interface
Parameters:
- DATA_W, 16: width of the data payload (operands, immediate).
- CTRL_W, 16: width of the control-flag bundle (RegWrite, MemRead, …).
- ADDR_W, 4: width of one register-address field.
- NUM_ADDR, 2: number of register-address fields carried.
- KILL_ADDR, all ones (ADDR_W bits): address code meaning "no register" to hazard/forwarding logic.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer accepts an entry this cycle.
- in_bubble  in  1  captured entry is turned into a bubble.
- in_ctrl  in  CTRL_W  control flags.
- in_data  in  DATA_W  payload.
- in_addr  in  NUM_ADDR*ADDR_W  register addresses; field i is bits [i*ADDR_W +: ADDR_W].
- flush  in  1  discard all held entries.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head.
- out_ctrl, out_data, out_addr  out  CTRL_W / DATA_W / NUM_ADDR*ADDR_W  head entry.
- occupancy  out  2  held entries: 0, 1 or 2.

## Operation
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- Bubble on capture: if in_bubble=1 at input fire, every address field is stored as KILL_ADDR and ctrl is stored as 0. Data is stored unchanged. The entry stays valid, so it is counted and forwarded.
- Empty head: whenever out_valid=0, out_ctrl=0 and every out_addr field = KILL_ADDR. out_data holds its last value.
- Slots: main (head, drives the outputs) and skid.
- Main empty or output fire:
  - if skid is valid, skid moves to main; skid becomes empty, or takes the input if an input fire occurs;
  - else the input fire loads main.
- Main full, no output fire, input fire: the input loads skid.
- Entries leave strictly in arrival order. None is duplicated or dropped, except by flush.
- Flush: synchronous and highest priority. Both slots become empty at the next edge. Any input fire in the same cycle is discarded. in_ready is not gated by flush.

## Timing
- Reset (async assert): out_valid=0, out_ctrl=0, out_addr=all KILL_ADDR, out_data=0, occupancy=0, skid empty, in_ready=1. A reset mid-transfer loses all entries; no partial entry is kept.
- Latency: one cycle from input fire to out_valid=1 when the buffer is empty.
- Throughput: one entry per cycle while out_ready=1.
- in_ready is registered and equals !skid_valid. It has no combinational path from out_ready.
- occupancy updates at the same edge as the slots.

## Configuration
- PIPE_STAGE_BUFFER_SKID_EN defined: two-slot behaviour as above; in_ready is registered.
- Not defined:
  - the skid slot is removed and occupancy never exceeds 1;
  - in_ready = !main_valid || out_ready, which is combinational from out_ready;
  - full throughput is kept. All other behaviour (bubble, flush, reset values, ordering) is identical.

## Structure
- Package pipe_buf_pkg holds:
  - the default KILL_ADDR function of ADDR_W;
  - the default widths;
  - the occupancy encoding constants (EMPTY=0, ONE=1, TWO=2).
- Sub-module pipe_buf_slot: one register slot (valid, ctrl, data, addr). It has a load enable, a clear (flush) and a kill input that applies the bubble transform. It is instantiated once for main and once for skid under the macro.

## Test plan
- Reset, then single entry ctrl=0x0005, data=0x1234, addr={3,7}, out_ready=1 → out_valid=1 one cycle later with the same values; occupancy 1, then 0.
- in_bubble=1 with addr={3,7}, ctrl=0x00FF, data=0xAAAA → out_addr={15,15}, out_ctrl=0, out_data=0xAAAA, out_valid=1.
- Stream 0..9 with out_ready held 0 for 3 cycles mid-stream (SKID_EN) → occupancy reaches 2, in_ready=0 one cycle later, output sequence exactly 0..9.
- Buffer holding 2 entries, flush=1 with in_valid=1 → next cycle out_valid=0, occupancy=0, the input entry never appears.
- Assert rst_n=0 asynchronously mid-stream → outputs go to reset values before the next clk edge, in_ready=1.
- Without SKID_EN, out_ready=0 with main full → in_ready=0 in the same cycle; with out_ready=1 → in_ready=1 and back-to-back throughput.

Source files
------------

// File: rtl/pipe_buf_pkg.sv
//------------------------------------------------------------------------------
// Module   : pipe_buf_pkg
// Purpose  : Shared defaults and occupancy encoding for pipe_stage_buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_buf_pkg;

  localparam int c_def_data_w   = 16;
  localparam int c_def_ctrl_w   = 16;
  localparam int c_def_addr_w   = 4;
  localparam int c_def_num_addr = 2;

  localparam logic [1:0] c_occ_empty = 2'd0;
  localparam logic [1:0] c_occ_one   = 2'd1;
  localparam logic [1:0] c_occ_two   = 2'd2;

  // All-ones code of the given address width; callers cast it down to ADDR_W.
  function automatic logic [31:0] default_kill_addr(input int unsigned aw);
    if (aw >= 32) return '1;
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_buf_slot.sv
//------------------------------------------------------------------------------
// Module   : pipe_buf_slot
// Purpose  : One pipeline entry register (valid, ctrl, data, addr) with
//            load / drop / synchronous clear and a bubble (kill) transform.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_buf_slot
  import pipe_buf_pkg::*;
#(
  parameter int              DATA_W    = c_def_data_w,
  parameter int              CTRL_W    = c_def_ctrl_w,
  parameter int              ADDR_W    = c_def_addr_w,
  parameter int              NUM_ADDR  = c_def_num_addr,
  parameter logic [ADDR_W-1:0] KILL_ADDR = ADDR_W'(default_kill_addr(ADDR_W))
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       drop,
  input  logic                       clear,
  input  logic                       kill,
  input  logic [CTRL_W-1:0]          d_ctrl,
  input  logic [DATA_W-1:0]          d_data,
  input  logic [NUM_ADDR*ADDR_W-1:0] d_addr,
  output logic                       slot_valid,
  output logic [CTRL_W-1:0]          slot_ctrl,
  output logic [DATA_W-1:0]          slot_data,
  output logic [NUM_ADDR*ADDR_W-1:0] slot_addr
);

  localparam logic [NUM_ADDR*ADDR_W-1:0] c_kill_vec = {NUM_ADDR{KILL_ADDR}};

  logic                       r_valid;
  logic [CTRL_W-1:0]          r_ctrl;
  logic [DATA_W-1:0]          r_data;
  logic [NUM_ADDR*ADDR_W-1:0] r_addr;

  // Clear wins over load so a flushed cycle never captures anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_addr  <= c_kill_vec;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_ctrl  <= kill ? '0 : d_ctrl;
      r_data  <= d_data;
      r_addr  <= kill ? c_kill_vec : d_addr;
    end else if (drop) begin
      r_valid <= 1'b0;
    end
  end

  assign slot_valid = r_valid;
  assign slot_ctrl  = r_ctrl;
  assign slot_data  = r_data;
  assign slot_addr  = r_addr;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buffer.sv
//------------------------------------------------------------------------------
// Module   : pipe_stage_buffer
// Purpose  : Valid/ready inter-stage pipeline register with flush and bubble
//            insertion. Define PIPE_STAGE_BUFFER_SKID_EN for the two-slot
//            (registered in_ready) variant; otherwise a single slot is used.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_buffer
  import pipe_buf_pkg::*;
#(
  parameter int              DATA_W    = c_def_data_w,
  parameter int              CTRL_W    = c_def_ctrl_w,
  parameter int              ADDR_W    = c_def_addr_w,
  parameter int              NUM_ADDR  = c_def_num_addr,
  parameter logic [ADDR_W-1:0] KILL_ADDR = ADDR_W'(default_kill_addr(ADDR_W))
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_bubble,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [NUM_ADDR*ADDR_W-1:0] in_addr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_data,
  output logic [NUM_ADDR*ADDR_W-1:0] out_addr,
  output logic [1:0]                 occupancy
);

  localparam logic [NUM_ADDR*ADDR_W-1:0] c_kill_vec = {NUM_ADDR{KILL_ADDR}};

  logic                       w_in_fire;
  logic                       w_out_fire;
  logic                       w_main_load;
  logic                       w_main_drop;
  logic                       w_main_kill;
  logic [CTRL_W-1:0]          w_main_d_ctrl;
  logic [DATA_W-1:0]          w_main_d_data;
  logic [NUM_ADDR*ADDR_W-1:0] w_main_d_addr;
  logic                       w_main_valid;
  logic [CTRL_W-1:0]          w_main_ctrl;
  logic [DATA_W-1:0]          w_main_data;
  logic [NUM_ADDR*ADDR_W-1:0] w_main_addr;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = w_main_valid && out_ready;

`ifdef PIPE_STAGE_BUFFER_SKID_EN
  logic                       w_main_free;
  logic                       w_skid_load;
  logic                       w_skid_drop;
  logic                       w_skid_valid;
  logic [CTRL_W-1:0]          w_skid_ctrl;
  logic [DATA_W-1:0]          w_skid_data;
  logic [NUM_ADDR*ADDR_W-1:0] w_skid_addr;

  always_comb begin
    w_main_free   = !w_main_valid || w_out_fire;
    w_main_load   = w_main_free && (w_skid_valid || w_in_fire);
    w_main_drop   = w_main_free && !w_skid_valid && !w_in_fire;
    w_main_kill   = in_bubble;
    w_main_d_ctrl = in_ctrl;
    w_main_d_data = in_data;
    w_main_d_addr = in_addr;
    // A held skid entry is older than the input, so it always goes first.
    if (w_skid_valid) begin
      w_main_kill   = 1'b0;
      w_main_d_ctrl = w_skid_ctrl;
      w_main_d_data = w_skid_data;
      w_main_d_addr = w_skid_addr;
    end
    w_skid_load = w_in_fire && (w_skid_valid || !w_main_free);
    w_skid_drop = w_main_free && w_skid_valid && !w_in_fire;
  end

  pipe_buf_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W),
    .NUM_ADDR(NUM_ADDR), .KILL_ADDR(KILL_ADDR)
  ) u_skid (
    .clk(clk), .rst_n(rst_n),
    .load(w_skid_load), .drop(w_skid_drop), .clear(flush), .kill(in_bubble),
    .d_ctrl(in_ctrl), .d_data(in_data), .d_addr(in_addr),
    .slot_valid(w_skid_valid), .slot_ctrl(w_skid_ctrl),
    .slot_data(w_skid_data), .slot_addr(w_skid_addr)
  );

  // Skid valid is a flop output, so in_ready is registered.
  assign in_ready  = !w_skid_valid;
  assign occupancy = (w_main_valid && w_skid_valid) ? c_occ_two :
                     w_main_valid ? c_occ_one : c_occ_empty;
`else
  always_comb begin
    w_main_load   = w_in_fire;
    w_main_drop   = w_out_fire && !w_in_fire;
    w_main_kill   = in_bubble;
    w_main_d_ctrl = in_ctrl;
    w_main_d_data = in_data;
    w_main_d_addr = in_addr;
  end

  assign in_ready  = !w_main_valid || out_ready;
  assign occupancy = w_main_valid ? c_occ_one : c_occ_empty;
`endif

  pipe_buf_slot #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W),
    .NUM_ADDR(NUM_ADDR), .KILL_ADDR(KILL_ADDR)
  ) u_main (
    .clk(clk), .rst_n(rst_n),
    .load(w_main_load), .drop(w_main_drop), .clear(flush), .kill(w_main_kill),
    .d_ctrl(w_main_d_ctrl), .d_data(w_main_d_data), .d_addr(w_main_d_addr),
    .slot_valid(w_main_valid), .slot_ctrl(w_main_ctrl),
    .slot_data(w_main_data), .slot_addr(w_main_addr)
  );

  // An empty head must look like "no register, no side effects" downstream.
  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
  assign out_addr  = w_main_valid ? w_main_addr : c_kill_vec;
  assign out_data  = w_main_data;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_stage_buffer
// Purpose  : Queue-based reference model plus directed and random stimulus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_bubble, flush;
  logic [15:0] in_ctrl, in_data;
  logic [7:0]  in_addr;
  logic        out_valid, out_ready;
  logic [15:0] out_ctrl, out_data;
  logic [7:0]  out_addr;
  logic [1:0]  occupancy;

  int checks   = 0;
  int failures = 0;

`ifdef PIPE_STAGE_BUFFER_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  pipe_stage_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_addr(in_addr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_addr(out_addr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [15:0] data;
    logic [7:0]  addr;
  } ent_t;

  ent_t        q[$];
  logic [15:0] last_data;

  function automatic bit m_in_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of at most CAP entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last_data = 16'h0;
    end else if (flush) begin
      q.delete();
    end else begin
      bit rdy, ofire;
      ent_t e;
      rdy   = m_in_ready();
      ofire = (q.size() > 0) && out_ready;
      if (ofire) void'(q.pop_front());
      if (in_valid && rdy) begin
        e.ctrl = in_bubble ? 16'h0 : in_ctrl;
        e.data = in_data;
        e.addr = in_bubble ? 8'hFF : in_addr;
        q.push_back(e);
      end
    end
    if (q.size() > 0) last_data = q[0].data;
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("in_ready",  64'(in_ready),  64'(m_in_ready()));
    chk("out_ctrl",  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].ctrl) : 64'h0);
    chk("out_addr",  64'(out_addr),  (q.size() > 0) ? 64'(q[0].addr) : 64'hFF);
    chk("out_data",  64'(out_data),  64'(last_data));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] rec[$];
    int k, max_occ, bad;
    rst_n = 1'b0; in_valid = 0; in_bubble = 0; flush = 0; out_ready = 0;
    in_ctrl = 0; in_data = 0; in_addr = 0;
    repeat (2) step();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_occ",   64'(occupancy), 0);
    chk("rst_ready", 64'(in_ready),  1);
    chk("rst_addr",  64'(out_addr),  64'hFF);
    chk("rst_data",  64'(out_data),  0);
    rst_n = 1'b1;
    step();

    // Single entry
    out_ready = 1; in_valid = 1; in_ctrl = 16'h0005; in_data = 16'h1234; in_addr = 8'h37;
    step();
    in_valid = 0;
    chk("t1_valid", 64'(out_valid), 1);
    chk("t1_ctrl",  64'(out_ctrl),  64'h0005);
    chk("t1_data",  64'(out_data),  64'h1234);
    chk("t1_addr",  64'(out_addr),  64'h37);
    chk("t1_occ1",  64'(occupancy), 1);
    step();
    chk("t1_occ0",  64'(occupancy), 0);

    // Bubble
    in_valid = 1; in_bubble = 1; in_ctrl = 16'h00FF; in_data = 16'hAAAA; in_addr = 8'h37;
    step();
    in_valid = 0; in_bubble = 0;
    chk("t2_valid", 64'(out_valid), 1);
    chk("t2_ctrl",  64'(out_ctrl),  0);
    chk("t2_data",  64'(out_data),  64'hAAAA);
    chk("t2_addr",  64'(out_addr),  64'hFF);
    step();

    // Stream 0..9 with a 3-cycle downstream stall
    k = 0; max_occ = 0;
    for (int cyc = 0; cyc < 60 && rec.size() < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (k < 10);
      in_data   = 16'(k); in_ctrl = 16'(k + 1); in_addr = 8'(k);
      #1;
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) rec.push_back(out_data);
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      step();
    end
    in_valid = 0;
    bad = 0;
    foreach (rec[i]) if (rec[i] !== 16'(i)) bad++;
    chk("t3_count", 64'(rec.size()), 10);
    chk("t3_order", 64'(bad), 0);
    chk("t3_maxocc", 64'(max_occ), 64'(CAP));
    repeat (3) step();

    // Flush with a simultaneous input
    out_ready = 0; in_valid = 1; in_data = 16'h0001;
    step();
    in_data = 16'h0002;
    step();
    chk("t4_occ_pre", 64'(occupancy), 64'(CAP));
    flush = 1; in_data = 16'h5A5A;
    step();
    flush = 0; in_valid = 0;
    chk("t4_valid", 64'(out_valid), 0);
    chk("t4_occ",   64'(occupancy), 0);
    out_ready = 1;
    repeat (3) step();
    chk("t4_stay_empty", 64'(out_valid), 0);

    // Asynchronous reset mid-stream
    out_ready = 0; in_valid = 1; in_data = 16'h0BEE;
    repeat (2) step();
    rst_n = 0;
    #1;
    chk("t5_valid", 64'(out_valid), 0);
    chk("t5_occ",   64'(occupancy), 0);
    chk("t5_ready", 64'(in_ready),  1);
    chk("t5_data",  64'(out_data),  0);
    chk("t5_addr",  64'(out_addr),  64'hFF);
    step();
    rst_n = 1; in_valid = 0;
    step();

    // in_ready path from out_ready with the head full
    out_ready = 0; in_valid = 1; in_data = 16'h0007;
    step();
    in_valid = 0;
    #1;
    chk("t6_ready_stall", 64'(in_ready), (CAP == 2) ? 64'h1 : 64'h0);
    out_ready = 1;
    #1;
    chk("t6_ready_go", 64'(in_ready), 1);
    in_valid = 1;
    repeat (3) step();
    chk("t6_occ", 64'(occupancy), 1);
    chk("t6_valid", 64'(out_valid), 1);
    in_valid = 0;
    step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_bubble = ($urandom_range(7) == 0);
      flush     = ($urandom_range(31) == 0);
      in_ctrl   = 16'($urandom);
      in_data   = 16'($urandom);
      in_addr   = 8'($urandom);
      step();
    end
    in_valid = 0; flush = 0; in_bubble = 0; out_ready = 1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
